// File: rtl/ex_muldiv_seq_if.sv
// rtl/ex_muldiv_seq_if.sv - ID/EX to M-extension sequencer handshake and result bus
interface ex_muldiv_seq_if;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_res;

    modport master (
        output i_start, i_op, i_a, i_b, i_flush,
        input  o_busy, o_done, o_res
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_flush,
        output o_busy, o_done, o_res
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer (optional MULDIV_FAST_PATH_EN)
module ex_muldiv_seq (
    input  logic               i_clk,
    input  logic               i_rst,
    ex_muldiv_seq_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        dz_q;
    logic        ovf_q;
    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] a_raw;
    logic [31:0] res_hold;

    logic        a_signed;
    logic        b_signed;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        start_neg;
    logic        start_dz;
    logic        start_ovf;
    logic        accept;
    logic        fast_go;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.i_op)
            3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
    end

    assign sign_a    = a_signed & bus.i_a[31];
    assign sign_b    = b_signed & bus.i_b[31];
    assign abs_a     = sign_a ? (32'd0 - bus.i_a) : bus.i_a;
    assign abs_b     = sign_b ? (32'd0 - bus.i_b) : bus.i_b;
    // Remainder takes the dividend's sign; product and quotient take the xor.
    assign start_neg = (bus.i_op[2] & bus.i_op[1]) ? sign_a : (sign_a ^ sign_b);
    assign start_dz  = bus.i_op[2] & (bus.i_b == 32'd0);
    assign start_ovf = bus.i_op[2] & ~bus.i_op[0]
                     & (bus.i_a == 32'h8000_0000) & (bus.i_b == 32'hFFFF_FFFF);
    assign accept    = (state == IDLE) & bus.i_start & ~bus.i_flush;

`ifdef MULDIV_FAST_PATH_EN
    assign fast_go = start_dz | start_ovf
                   | (~bus.i_op[2] & ((bus.i_a == 32'd0) | (bus.i_b == 32'd0)));
`else
    assign fast_go = 1'b0;
`endif

    // One 64-bit adder serves both: product accumulate, or trial subtract of the divisor.
    logic [32:0] rem_sh;
    logic [63:0] add_x;
    logic [63:0] add_y;
    logic [63:0] sum;
    logic        div_ge;

    assign rem_sh = {rem, quot[31]};
    assign add_x  = op_q[2] ? {31'd0, rem_sh} : prod;
    assign add_y  = op_q[2] ? ~{32'd0, mplier} : mcand;
    assign sum    = add_x + add_y + {63'd0, op_q[2]};
    assign div_ge = ~sum[63];

    logic [63:0] prod_c;
    logic [31:0] quot_c;
    logic [31:0] rem_c;
    logic [31:0] result_c;

    assign prod_c = neg_q ? (64'd0 - prod) : prod;
    assign quot_c = neg_q ? (32'd0 - quot) : quot;
    assign rem_c  = neg_q ? (32'd0 - rem)  : rem;

    always_comb begin
        case (op_q)
            3'd0:             result_c = prod_c[31:0];
            3'd1, 3'd2, 3'd3: result_c = prod_c[63:32];
            3'd4, 3'd5:       result_c = quot_c;
            default:          result_c = rem_c;
        endcase
        if (dz_q)
            result_c = op_q[1] ? a_raw : 32'hFFFF_FFFF;
        else if (ovf_q)
            result_c = op_q[1] ? 32'd0 : 32'h8000_0000;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= 5'd0;
            prod     <= 64'd0;
            mcand    <= 64'd0;
            mplier   <= 32'd0;
            quot     <= 32'd0;
            rem      <= 32'd0;
            a_raw    <= 32'd0;
            res_hold <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.i_op;
                        neg_q  <= start_neg;
                        dz_q   <= start_dz;
                        ovf_q  <= start_ovf;
                        cnt    <= 5'd0;
                        prod   <= 64'd0;
                        mcand  <= {32'd0, abs_a};
                        mplier <= abs_b;
                        quot   <= abs_a;
                        rem    <= 32'd0;
                        a_raw  <= bus.i_a;
                        state  <= fast_go ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (bus.i_flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (op_q[2]) begin
                            rem  <= div_ge ? sum[31:0] : rem_sh[31:0];
                            quot <= {quot[30:0], div_ge};
                        end else begin
                            if (mplier[0])
                                prod <= sum;
                            mcand  <= {mcand[62:0], 1'b0};
                            mplier <= {1'b0, mplier[31:1]};
                        end
                        if (cnt == 5'd31)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.i_flush)
                        res_hold <= result_c;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy = ~i_rst & ((state == CALC) | ((state == IDLE) & bus.i_start & ~bus.i_flush));
    assign bus.o_done = (state == DONE) & ~bus.i_flush;
    assign bus.o_res  = {32'd0, (state == DONE) ? result_c : res_hold};
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - self-checking bench for ex_muldiv_seq against an arithmetic model
module tb_ex_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ex_muldiv_seq_if bus ();

    ex_muldiv_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s, q;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub_s = {32'd0, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb;   r = p[31:0];  end
            3'd1: begin p = sa * sb;   r = p[63:32]; end
            3'd2: begin p = sa * ub_s; r = p[63:32]; end
            3'd3: begin p = ua * ub;   r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin q = sa / sb; r = q[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'd0;
                else begin q = sa % sb; r = q[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_PATH_EN
        if ((op[2] && b == 0)
            || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            || (!op[2] && (a == 0 || b == 0)))
            return 1;
`endif
        return 33;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the operation ends.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output bit busy_ok);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        @(negedge clk);
        busy_ok = (bus.o_busy === 1'b1);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        lat = 99;
        res = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                lat = n;
                res = bus.o_res;
                if (bus.o_busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_op = 3'd0;
        bus.i_a = 32'd3;
        bus.i_b = 32'd4;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_busy, bus.o_done, bus.o_res} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b res=%h, required all zero", bus.o_busy, bus.o_done, bus.o_res);
        end
        bus.i_start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [2:0]  t_op [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] t_a  [4] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] t_b  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2};
        logic [31:0] t_e  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        logic [63:0] res;
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat, bok);
            n_cmp++;
            if (res !== {32'd0, t_e[i]}) begin
                n_err++;
                $display("FAIL mul_result[%0d]: got %h, required %h", i, res, {32'd0, t_e[i]});
            end
            n_cmp++;
            if (lat !== 33 || !bok) begin
                n_err++;
                $display("FAIL mul_timing[%0d]: latency %0d busy_ok %0b, required 33 and 1", i, lat, bok);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] t_a  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                  32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_e  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                  32'h8000_0000, 32'd0};
        logic [63:0] res;
        int lat;
        bit bok;
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat, bok);
            n_cmp++;
            if (res !== {32'd0, t_e[i]}) begin
                n_err++;
                $display("FAIL div_result[%0d]: got %h, required %h", i, res, {32'd0, t_e[i]});
            end
            n_cmp++;
            if (lat !== exp_lat(t_op[i], t_a[i], t_b[i]) || !bok) begin
                n_err++;
                $display("FAIL div_timing[%0d]: latency %0d busy_ok %0b, required %0d and 1",
                         i, lat, bok, exp_lat(t_op[i], t_a[i], t_b[i]));
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int lat;
        bit bok;
        bus.i_start = 1'b1;
        bus.i_op = 3'd0;
        bus.i_a = 32'd12345;
        bus.i_b = 32'd6789;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.i_flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.o_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_calc_done: got %b, required 0", bus.o_done);
        end
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_calc_idle: busy=%b done=%b, required 0 0", bus.o_busy, bus.o_done);
        end
        run_op(3'd5, 32'd9, 32'd3, res, lat, bok);
        n_cmp++;
        if (res !== 64'd3 || lat !== 33) begin
            n_err++;
            $display("FAIL flush_next_op: got %h lat %0d, required 3 lat 33", res, lat);
        end
        // Flush arriving in the DONE cycle
        bus.i_start = 1'b1;
        bus.i_op = 3'd5;
        bus.i_a = 32'd100;
        bus.i_b = 32'd7;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (32) @(posedge clk);
        #1 bus.i_flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_done: done=%b busy=%b, required 0 0", bus.o_done, bus.o_busy);
        end
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        // Flush and start together in IDLE
        bus.i_start = 1'b1;
        bus.i_flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_start_busy: got %b, required 0", bus.o_busy);
        end
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) lat++;
        end
        n_cmp++;
        if (lat !== 0) begin
            n_err++;
            $display("FAIL flush_start_ignored: %0d active cycles, required 0", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.i_start = 1'b1;
        bus.i_op = 3'd4;
        bus.i_a = 32'hDEAD_BEEF;
        bus.i_b = 32'd77;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_busy, bus.o_done, bus.o_res} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b res=%h, required all zero", bus.o_busy, bus.o_done, bus.o_res);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: %0d done pulses, required 0", seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [63:0] res;
        logic [2:0]  op;
        logic [31:0] a, b;
        int lat;
        bit bok;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: a = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                4: b = 32'($urandom_range(0, 15)) - 32'd8;
                default: ;
            endcase
            run_op(op, a, b, res, lat, bok);
            n_cmp++;
            if (res !== {32'd0, ref_res(op, a, b)} || lat !== exp_lat(op, a, b) || !bok) begin
                n_err++;
                $display("FAIL random[%0d] op%0d a=%h b=%h: res %h lat %0d busy_ok %0b, required %h lat %0d",
                         i, op, a, b, res, lat, bok, {32'd0, ref_res(op, a, b)}, exp_lat(op, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative RV32M multiply/divide sequencer beside the EX stage. It accepts one M-extension operation from ID/EX and holds the pipeline stalled while it runs. It then delivers a 64-bit zero-extended result, in the same format as the ALU output, into EX/MEM. It owns the only shared adder/shifter used for MUL* and DIV*/REM*, and sequences it for 32 iterations per operation.

## Interface
- No parameters; operand width fixed at 32, result bus 64.
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  ID/EX holds a valid M-op; sampled only in IDLE
- i_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_a  in  32  rs1 value
- i_b  in  32  rs2 value
- i_flush  in  1  branch/jump flush; aborts any operation
- o_busy  out  1  stall request to IF/ID/EX; combinational
- o_done  out  1  one-cycle result-valid pulse
- o_res  out  64  {32'b0, result}; valid only while o_done=1

## Operation
- States: IDLE, CALC, DONE.
- IDLE→CALC on i_start & !i_flush.
  - Latch the op.
  - Latch |a| and |b| per the op's signedness (MULH: both signed; MULHSU: a signed, b unsigned; DIV/REM: both signed; U-ops: raw).
  - Latch result sign. For mul it is sign(a)^sign(b). For quotient it is sign(a)^sign(b). For remainder it is sign(a).
  - Clear 5-bit iteration counter.
- CALC, multiply: shift-add over a 64-bit product register. Each iteration adds |a|<<k when b[k]=1.
- CALC, divide: restoring division. 32-bit quotient and 33-bit partial remainder; each iteration shifts in one dividend bit.
- CALC→DONE when counter==31, i.e. after 32 iterations. Counter increments every CALC cycle.
- DONE:
  - Apply sign correction (two's-complement negate when the sign flag is set).
  - Select the result: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Drive o_res and o_done=1; next edge → IDLE.
- Special cases (RISC-V defined):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → i_a.
  - Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0.
  - Both are flagged at accept and override the datapath result in DONE.
- o_busy = (state==CALC) | (state==IDLE & i_start & !i_flush).
  - o_busy is 0 in DONE, so the pipeline advances on the same edge that captures o_res into EX/MEM.
- i_start outside IDLE is ignored; no queueing.
- i_flush in CALC or DONE → IDLE at next edge. o_done is forced to 0 combinationally in that cycle, and no result is delivered.
- i_flush and i_start in the same IDLE cycle: flush wins, and the op is not accepted.

## Timing
- Reset (async, immediate): state IDLE, counter 0, o_done 0, o_res 0, o_busy 0 (i_start is ignored while i_rst=1).
- Accept edge E0. CALC occupies the cycles after E0..E31. DONE is the cycle after E32, so o_done is high 33 cycles after i_start is first seen.
- o_res is held at its last value outside DONE but must not be relied on.
- Reset asserted mid-operation discards all state; no o_done.
- After DONE, the next i_start is accepted in the immediately following cycle.

## Configuration
- MULDIV_FAST_PATH_EN defined:
  - Divide-by-zero and signed-overflow ops go IDLE→DONE directly (o_done in the cycle after accept, 1 stall cycle).
  - MUL* with either operand zero also goes IDLE→DONE, with result 0.
- Undefined: every op takes the full 32 CALC cycles; results are identical.

## Test plan
- MUL a=7, b=0xFFFFFFFD → o_res=0x00000000_FFFFFFEB; o_done exactly 33 cycles after start; o_busy high for cycles 0..32.
- MULH a=b=0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5. With MULDIV_FAST_PATH_EN, o_done arrives 1 cycle after accept; without it, 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Start MUL, assert i_flush at CALC iteration 10 → no o_done, o_busy 0 next cycle. New DIVU 9/3 started the following cycle → 3.
- Assert i_rst in mid-CALC → outputs zero immediately, no o_done after release.
